// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/MMIO responder: SRAM cycles with programmable wait states plus
// the keyboard/display device registers, answered with a one-cycle ready pulse.
module lc3_mem_ctrl #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [7:0]  DEV_BASE    = 8'hFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic        ready,
    output logic [15:0] mem_data,
    output logic        sram_en,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ack,
    output logic        kbd_irq
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SRAM   = 3'd1;
    localparam logic [2:0] DEV    = 3'd2;
    localparam logic [2:0] DSTALL = 3'd3;
    localparam logic [2:0] RDY    = 3'd4;

    localparam logic [7:0] OFS_KBSR = 8'h00;
    localparam logic [7:0] OFS_KBDR = 8'h02;
    localparam logic [7:0] OFS_DSR  = 8'h04;
    localparam logic [7:0] OFS_DDR  = 8'h06;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, wdata_q;
    logic        wr_q;
    logic [15:0] mem_data_q;
    logic        kbsr_rdy_q, kbsr_ie_q;
    logic [7:0]  kbdr_q, ddr_q;
    logic        dsp_valid_q;

    logic        is_kbsr, is_kbdr, is_dsr, is_ddr;
    logic        sram_last, ddr_load, dev_rd;

    assign is_kbsr   = (addr_q[7:0] == OFS_KBSR);
    assign is_kbdr   = (addr_q[7:0] == OFS_KBDR);
    assign is_dsr    = (addr_q[7:0] == OFS_DSR);
    assign is_ddr    = (addr_q[7:0] == OFS_DDR);
    assign sram_last = (state_q == SRAM) && (cnt_q == WAIT_LAST);
    assign dev_rd    = (state_q == DEV) && !wr_q;

    // A DDR write lands directly when the display is free, otherwise once the
    // pending character is acknowledged (or was acknowledged while entering DSTALL).
    assign ddr_load = ((state_q == DEV) && wr_q && is_ddr && !dsp_valid_q) ||
                      ((state_q == DSTALL) && (!dsp_valid_q || dsp_ack));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mio_en) state_d = (mar[15:8] == DEV_BASE) ? DEV : SRAM;
            end
            SRAM: begin
                if (sram_last) state_d = RDY;
                else           cnt_d   = cnt_q + 4'd1;
            end
            DEV: begin
                if (wr_q && is_ddr && dsp_valid_q) state_d = DSTALL;
                else                               state_d = RDY;
            end
            DSTALL: if (ddr_load) state_d = RDY;
            RDY:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            mem_data_q  <= '0;
            kbsr_rdy_q  <= 1'b0;
            kbsr_ie_q   <= 1'b0;
            kbdr_q      <= '0;
            ddr_q       <= '0;
            dsp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && mio_en) begin
                addr_q  <= mar;
                wdata_q <= mdr_in;
                wr_q    <= r_w;
            end

            if (sram_last && !wr_q) mem_data_q <= sram_rdata;

            if (dev_rd) begin
                if (addr_q[15:8] != DEV_BASE) mem_data_q <= '0;
                else if (is_kbsr)             mem_data_q <= {kbsr_rdy_q, kbsr_ie_q, 14'd0};
                else if (is_kbdr)             mem_data_q <= {8'h00, kbdr_q};
                else if (is_dsr)              mem_data_q <= {~dsp_valid_q, 15'd0};
                else if (is_ddr)              mem_data_q <= {8'h00, ddr_q};
                else                          mem_data_q <= '0;
            end

            if (state_q == DEV && wr_q && is_kbsr) kbsr_ie_q <= wdata_q[14];

            // A new keystroke wins over the read-clear of the ready flag.
            if (kbd_valid) begin
                kbdr_q     <= kbd_data;
                kbsr_rdy_q <= 1'b1;
            end else if (dev_rd && is_kbdr) begin
                kbsr_rdy_q <= 1'b0;
            end

            if (dsp_ack && dsp_valid_q) dsp_valid_q <= 1'b0;
            if (ddr_load) begin
                ddr_q       <= wdata_q[7:0];
                dsp_valid_q <= 1'b1;
            end
        end
    end

    assign ready      = (state_q == RDY);
    assign mem_data   = mem_data_q;
    assign sram_en    = (state_q == SRAM);
    assign sram_we    = sram_en && wr_q;
    assign sram_addr  = sram_en ? addr_q  : '0;
    assign sram_wdata = sram_en ? wdata_q : '0;
    assign dsp_valid  = dsp_valid_q;
    assign dsp_data   = ddr_q;
    assign kbd_irq    = kbsr_rdy_q && kbsr_ie_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl: requests push expected responses, a
// negedge monitor pops them on each ready pulse and checks data and latency.
module tb_lc3_mem_ctrl;

    localparam int unsigned WS = 2;

    logic        clk = 1'b0;
    logic        rst, mio_en, r_w, kbd_valid, dsp_ack;
    logic [15:0] mar, mdr_in, sram_rdata, sram_addr, sram_wdata, mem_data;
    logic [7:0]  kbd_data, dsp_data;
    logic        ready, sram_en, sram_we, dsp_valid, kbd_irq;

    lc3_mem_ctrl #(.WAIT_STATES(WS), .DEV_BASE(8'hFE)) dut (
        .clk(clk), .rst(rst), .mio_en(mio_en), .r_w(r_w), .mar(mar), .mdr_in(mdr_in),
        .ready(ready), .mem_data(mem_data), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .kbd_valid(kbd_valid), .kbd_data(kbd_data), .dsp_valid(dsp_valid),
        .dsp_data(dsp_data), .dsp_ack(dsp_ack), .kbd_irq(kbd_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          rd;
        logic [15:0] data;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int          total, bad;
    int unsigned cyc, en_cnt, we_cnt, rdy_cnt;

    // SRAM model indexed by {addr[15:12], addr[3:0]}; 0x3000 preloaded with 0x1234.
    logic [15:0] mem [0:255];
    bit          mem_init;
    assign sram_rdata = mem[{sram_addr[15:12], sram_addr[3:0]}];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h30] <= 16'h1234;
            mem_init   <= 1'b1;
        end else if (sram_en && sram_we) begin
            mem[{sram_addr[15:12], sram_addr[3:0]}] <= sram_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sram_en) begin
            en_cnt++;
            if (sram_we) we_cnt++;
        end
        if (ready) begin
            rdy_cnt++;
            if (sb.size() == 0) begin
                check_eq("spurious_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq({e.tag, "_lat"}, cyc, e.due);
                if (e.rd) check_eq(e.tag, {16'd0, mem_data}, {16'd0, e.data});
            end
        end
    end

    task automatic issue(input string tag, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [15:0] exp,
                         input int unsigned lat, input bit track);
        exp_t e;
        @(posedge clk); #1;
        mio_en = 1'b1; r_w = wr; mar = addr; mdr_in = wd;
        if (track) begin
            e.tag = tag; e.rd = !wr; e.data = exp; e.due = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        mio_en = 1'b0; r_w = 1'($urandom); mar = 16'($urandom); mdr_in = 16'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 64 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check_eq("timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        issue(tag, 1'b0, addr, 16'h0000, exp, (addr[15:8] == 8'hFE) ? 2 : WS + 2, 1'b1);
        wait_done();
    endtask

    task automatic wr(input string tag, input logic [15:0] addr, input logic [15:0] data);
        issue(tag, 1'b1, addr, data, 16'h0000, (addr[15:8] == 8'hFE) ? 2 : WS + 2, 1'b1);
        wait_done();
    endtask

    task automatic kbd_pulse(input logic [7:0] ch);
        @(posedge clk); #1; kbd_valid = 1'b1; kbd_data = ch;
        @(posedge clk); #1; kbd_valid = 1'b0;
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1; dsp_ack = 1'b1;
        @(posedge clk); #1; dsp_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned en0, we0, r0;
        logic [15:0] a, d;
        rst = 1'b0; mio_en = 1'b0; r_w = 1'b0; mar = '0; mdr_in = '0;
        kbd_valid = 1'b0; kbd_data = '0; dsp_ack = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_eq("rst_ready", ready, 0);
        check_eq("rst_mem_data", mem_data, 0);
        check_eq("rst_sram_en", sram_en, 0);
        check_eq("rst_dsp_valid", dsp_valid, 0);
        check_eq("rst_kbd_irq", kbd_irq, 0);
        rst = 1'b1;

        en0 = en_cnt; we0 = we_cnt;
        rd("sram_rd_3000", 16'h3000, 16'h1234);
        check_eq("sram_rd_en_cycles", en_cnt - en0, WS + 1);
        check_eq("sram_rd_we_cycles", we_cnt - we0, 0);

        en0 = en_cnt; we0 = we_cnt;
        wr("sram_wr_4000", 16'h4000, 16'hABCD);
        check_eq("sram_wr_en_cycles", en_cnt - en0, WS + 1);
        check_eq("sram_wr_we_cycles", we_cnt - we0, WS + 1);
        rd("sram_rb_4000", 16'h4000, 16'hABCD);

        for (int i = 0; i < 4; i++) begin
            a = {4'(i + 5), 8'($urandom), 4'(i)};
            d = 16'($urandom);
            wr("sram_wr_rand", a, d);
            rd("sram_rb_rand", a, d);
        end

        rd("dev_unmapped_rd", 16'hFE10, 16'h0000);
        wr("dev_unmapped_wr", 16'hFE12, 16'h5A5A);
        rd("dev_unmapped_rb", 16'hFE12, 16'h0000);

        kbd_pulse(8'h41);
        rd("kbsr_full", 16'hFE00, 16'h8000);
        rd("kbdr_A", 16'hFE02, 16'h0041);
        rd("kbsr_cleared", 16'hFE00, 16'h0000);
        wr("kbsr_ie", 16'hFE00, 16'h4000);
        check_eq("irq_ie_only", kbd_irq, 0);
        kbd_pulse(8'h58);
        check_eq("irq_set", kbd_irq, 1);
        rd("kbsr_ie_full", 16'hFE00, 16'hC000);
        rd("kbdr_X", 16'hFE02, 16'h0058);
        check_eq("irq_cleared", kbd_irq, 0);
        wr("kbsr_ie_off", 16'hFE00, 16'h0000);

        kbd_pulse(8'h41);
        issue("kbdr_collide", 1'b0, 16'hFE02, 16'h0000, 16'h0041, 2, 1'b1);
        kbd_valid = 1'b1; kbd_data = 8'h42;
        @(posedge clk); #1; kbd_valid = 1'b0;
        wait_done();
        rd("kbsr_after_collide", 16'hFE00, 16'h8000);
        rd("kbdr_B", 16'hFE02, 16'h0042);

        wr("ddr_wr_48", 16'hFE06, 16'h0048);
        check_eq("dsp_valid_48", dsp_valid, 1);
        check_eq("dsp_data_48", dsp_data, 8'h48);
        rd("dsr_busy", 16'hFE04, 16'h0000);
        issue("ddr_wr_49_stall", 1'b1, 16'hFE06, 16'h0049, 16'h0000, 6, 1'b1);
        repeat (4) @(posedge clk); #1;
        check_eq("stall_ready_withheld", sb.size(), 1);
        check_eq("stall_dsp_data_48", dsp_data, 8'h48);
        dsp_ack = 1'b1;
        @(posedge clk); #1; dsp_ack = 1'b0;
        wait_done();
        check_eq("dsp_data_49", dsp_data, 8'h49);
        check_eq("dsp_valid_49", dsp_valid, 1);

        issue("ddr_wr_4A_ack", 1'b1, 16'hFE06, 16'h004A, 16'h0000, 3, 1'b1);
        dsp_ack = 1'b1;
        @(posedge clk); #1; dsp_ack = 1'b0;
        wait_done();
        check_eq("dsp_data_4A", dsp_data, 8'h4A);
        check_eq("dsp_valid_4A", dsp_valid, 1);
        ack_pulse();
        check_eq("dsp_valid_acked", dsp_valid, 0);
        rd("dsr_idle", 16'hFE04, 16'h8000);
        rd("ddr_rd", 16'hFE06, 16'h004A);

        kbd_pulse(8'h33);
        wr("kbsr_ie_pre_rst", 16'hFE00, 16'h4000);
        wr("ddr_wr_pre_rst", 16'hFE06, 16'h0055);
        check_eq("irq_pre_rst", kbd_irq, 1);
        r0 = rdy_cnt;
        issue("rst_abort", 1'b0, 16'h3000, 16'h0000, 16'h0000, WS + 2, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(posedge clk); #1;
        check_eq("rst_abort_no_ready", rdy_cnt - r0, 0);
        check_eq("rst_abort_mem_data", mem_data, 0);
        check_eq("rst_abort_dsp_valid", dsp_valid, 0);
        check_eq("rst_abort_irq", kbd_irq, 0);
        rd("rst_kbsr", 16'hFE00, 16'h0000);
        rd("rst_dsr", 16'hFE04, 16'h8000);
        rd("rst_kbdr", 16'hFE02, 16'h0000);
        rd("rst_ddr", 16'hFE06, 16'h0000);
        rd("post_rst_sram", 16'h3000, 16'h1234);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
